// File: rtl/shared_bus_pkg.sv
// Shared definitions for the shared-bus arbiter: FSM state encoding and the
// idle (park) value driven onto the bus when nobody owns it.
package shared_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_e;

  localparam int PARK_MAX_W = 256;

  // Returned wide; callers keep the low WIDTH bits.
  function automatic logic [PARK_MAX_W-1:0] park_val(input int pull, input int width);
    logic [PARK_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < PARK_MAX_W; i++) begin
      if (pull != 0 && i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/shared_bus_arb_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from
// ptr+1, wrapping at N_REQ-1 back to 0.
module rr_pick
  import shared_bus_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  always_comb begin
    int   idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/shared_bus_arb.sv
// Round-robin arbiter for a shared bus with one turnaround cycle per tenure.
// Optional hold-limit timeout enabled by defining SHARED_BUS_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | bus parked, pick a winner if anyone requests
// GRANT | owner (ptr_q) drives the bus
// TURN  | one parked cycle between tenures
module shared_bus_arb
  import shared_bus_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 9,
  parameter int PULL     = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       last,
  input  logic [N_REQ*WIDTH-1:0] data_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       bus_out,
  output logic                   bus_valid,
  output logic                   tmo
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [PARK_MAX_W-1:0] PARK_FULL = park_val(PULL, WIDTH);
  localparam logic [WIDTH-1:0]      PARK      = PARK_FULL[WIDTH-1:0];

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] winner;
  logic             win_valid;
  logic [PTR_W-1:0] win_idx;
  logic             own_rel;
  logic             hold_done;

  rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner),
    .valid  (win_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner[i]) win_idx = PTR_W'(i);
    end
  end

  // ptr_q doubles as the owner index while in GRANT.
  assign own_rel = !req[ptr_q] || last[ptr_q];

`ifdef SHARED_BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_HOLD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;

  assign hold_done = (cnt_q == HOLD_LAST);

  always_comb begin
    cnt_d = cnt_q;
    tmo_d = 1'b0;
    if (state_q == IDLE && win_valid) begin
      cnt_d = '0;
    end else if (state_q == GRANT) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      tmo_d = !own_rel && hold_done;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign tmo = tmo_q;
`else
  logic unused_hold;
  assign unused_hold = ^MAX_HOLD;
  assign hold_done   = 1'b0;
  assign tmo         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = GRANT;
          gnt_d   = winner;
          ptr_d   = win_idx;
        end
      end
      GRANT: begin
        if (own_rel || hold_done) begin
          state_d = TURN;
          gnt_d   = '0;
        end
      end
      TURN: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= PTR_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    bus_out = PARK;
    if (state_q == GRANT) bus_out = data_in[int'(ptr_q)*WIDTH +: WIDTH];
  end

  assign bus_valid = (state_q == GRANT);
  assign gnt       = gnt_q;

endmodule

// File: tb/tb_shared_bus_arb.sv
// Scoreboarded bench for shared_bus_arb: expected grant order is queued as
// requests are driven and popped as grants appear on the bus.
module tb_shared_bus_arb;

  localparam int N  = 4;
  localparam int W  = 9;
  localparam int MH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N-1:0]     last;
  logic [N*W-1:0]   data_in;
  logic [N-1:0]     gnt;
  logic [W-1:0]     bus_out;
  logic             bus_valid;
  logic             tmo;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  shared_bus_arb #(.N_REQ(N), .WIDTH(W), .PULL(1), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .last      (last),
    .data_in   (data_in),
    .gnt       (gnt),
    .bus_out   (bus_out),
    .bus_valid (bus_valid),
    .tmo       (tmo)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_gnt(input int budget, output logic [N-1:0] g, output int idle);
    g    = '0;
    idle = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (gnt !== '0) begin
        g = gnt;
        break;
      end
      idle++;
    end
  endtask

  task automatic pop_exp(output logic [N-1:0] e);
    int idx;
    e = '0;
    if (exp_q.size() == 0) begin
      e = 'x;
    end else begin
      idx    = exp_q.pop_front();
      e[idx] = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 4'b1111;
    last = '0;
    for (int i = 0; i < N; i++) data_in[i*W +: W] = W'(9'h011 * (i + 1));
    repeat (2) @(negedge clk);
    n_tests++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_tests++;
    if (bus_out !== 9'h1FF) begin n_fail++; $display("FAIL reset_bus: got %h want 1ff", bus_out); end
    n_tests++;
    if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus_valid); end
    n_tests++;
    if (tmo !== 1'b0) begin n_fail++; $display("FAIL reset_tmo: got %b want 0", tmo); end
    rst = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL idle_no_req: got %b want 0000", gnt); end
  endtask

  task automatic test_fairness();
    logic [N-1:0] g, e;
    int idle;
    req = 4'b1111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    for (int t = 0; t < 5; t++) begin
      wait_gnt(10, g, idle);
      pop_exp(e);
      n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL fair_order[%0d]: got %b want %b", t, g, e); end
      if (t == 0) begin
        n_tests++;
        if (idle !== 0) begin n_fail++; $display("FAIL fair_latency: got %0d idle want 0", idle); end
      end else begin
        n_tests++;
        if (idle + 1 !== 2) begin n_fail++; $display("FAIL fair_gap[%0d]: got %0d idle want 2", t, idle + 1); end
      end
      last = g;
      @(negedge clk);
      n_tests++;
      if (gnt !== 4'b0000 || bus_valid !== 1'b0) begin
        n_fail++; $display("FAIL fair_turn[%0d]: got gnt %b valid %b want 0000/0", t, gnt, bus_valid);
      end
      last = '0;
    end
    req = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL fair_idle: got %b want 0000", gnt); end
  endtask

  task automatic test_data_path();
    logic [N-1:0] g, e;
    int idle;
    data_in[2*W +: W] = 9'h0A5;
    req = 4'b0100;
    exp_q.push_back(2);
    wait_gnt(10, g, idle);
    pop_exp(e);
    n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL dp_gnt: got %b want %b", g, e); end
    n_tests++;
    if (bus_out !== 9'h0A5 || bus_valid !== 1'b1) begin
      n_fail++; $display("FAIL dp_bus: got %h/%b want 0a5/1", bus_out, bus_valid);
    end
    data_in[2*W +: W] = 9'h15A;
    #1;
    n_tests++;
    if (bus_out !== 9'h15A) begin n_fail++; $display("FAIL dp_comb: got %h want 15a", bus_out); end
    last = 4'b0100;
    @(negedge clk);
    n_tests++;
    if (bus_out !== 9'h1FF || bus_valid !== 1'b0 || gnt !== 4'b0000) begin
      n_fail++; $display("FAIL dp_turn: got %h/%b/%b want 1ff/0/0000", bus_out, bus_valid, gnt);
    end
    req  = '0;
    last = '0;
    @(negedge clk);
  endtask

  task automatic test_simul_release();
    logic [N-1:0] g, e;
    int idle;
    req = 4'b0010;
    exp_q.push_back(1);
    wait_gnt(10, g, idle);
    pop_exp(e);
    n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL sr_gnt1: got %b want %b", g, e); end
    req  = 4'b1010;
    last = 4'b1000;
    @(negedge clk);
    n_tests++;
    if (gnt !== 4'b0010) begin n_fail++; $display("FAIL sr_nonowner_last: got %b want 0010", gnt); end
    req  = 4'b1000;
    last = 4'b0010;
    exp_q.push_back(3);
    @(negedge clk);
    n_tests++;
    if (gnt !== 4'b0000 || tmo !== 1'b0) begin
      n_fail++; $display("FAIL sr_turn: got gnt %b tmo %b want 0000/0", gnt, tmo);
    end
    last = '0;
    wait_gnt(10, g, idle);
    pop_exp(e);
    n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL sr_next: got %b want %b", g, e); end
    n_tests++;
    if (idle !== 1) begin n_fail++; $display("FAIL sr_single_turn: got %0d idle after turn want 1", idle); end
    req  = '0;
    last = 4'b1000;
    @(negedge clk);
    last = '0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic [N-1:0] g, e;
    int idle;
    int held;
    int tmo_cnt;
    req = 4'b1000;
    exp_q.push_back(3);
    wait_gnt(10, g, idle);
    pop_exp(e);
    n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL to_gnt: got %b want %b", g, e); end
`ifdef SHARED_BUS_ARB_TIMEOUT_EN
    held = 1;
    tmo_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt[3] !== 1'b1) break;
      if (tmo === 1'b1) tmo_cnt++;
      held++;
    end
    n_tests++;
    if (held !== MH) begin n_fail++; $display("FAIL to_hold: got %0d cycles want %0d", held, MH); end
    n_tests++;
    if (tmo !== 1'b1 || tmo_cnt !== 0) begin
      n_fail++; $display("FAIL to_pulse: got tmo %b early %0d want 1/0", tmo, tmo_cnt);
    end
    exp_q.push_back(3);
    @(negedge clk);
    n_tests++;
    if (tmo !== 1'b0) begin n_fail++; $display("FAIL to_pulse_len: got %b want 0", tmo); end
    wait_gnt(10, g, idle);
    pop_exp(e);
    n_tests++;
    if (g !== e || idle !== 0) begin
      n_fail++; $display("FAIL to_regrant: got %b idle %0d want %b idle 0", g, idle, e);
    end
`else
    tmo_cnt = 0;
    held = 1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (tmo === 1'b1) tmo_cnt++;
      if (gnt[3] === 1'b1) held++;
    end
    n_tests++;
    if (held !== 121 || gnt !== 4'b1000) begin
      n_fail++; $display("FAIL to_hold_forever: got %0d cycles gnt %b want 121/1000", held, gnt);
    end
    n_tests++;
    if (tmo_cnt !== 0) begin n_fail++; $display("FAIL to_tmo_tied: got %0d pulses want 0", tmo_cnt); end
`endif
    req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    logic [N-1:0] g, e;
    int idle;
    req = 4'b0010;
    exp_q.push_back(1);
    wait_gnt(10, g, idle);
    pop_exp(e);
    n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL mr_gnt1: got %b want %b", g, e); end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (gnt !== 4'b0000 || bus_valid !== 1'b0 || bus_out !== 9'h1FF) begin
      n_fail++; $display("FAIL mr_drop: got %b/%b/%h want 0000/0/1ff", gnt, bus_valid, bus_out);
    end
    req = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(0);
    wait_gnt(10, g, idle);
    pop_exp(e);
    n_tests++;
    if (g !== e || idle !== 0) begin
      n_fail++; $display("FAIL mr_first: got %b idle %0d want %b idle 0", g, idle, e);
    end
    req = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    req     = '0;
    last    = '0;
    data_in = '0;
    test_reset();
    test_fairness();
    test_data_path();
    test_simul_release();
    test_timeout();
    test_mid_reset();
    n_tests++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL sb_drain: got %0d left want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
